shift_xfer_ctrl: RTL

//  Sequencer for an 8-bit right-shifting serial register: accepts a parallel word on a

---
 rtl/shift_xfer_ctrl_pkg.sv | 16 +
 rtl/shift_reg_pload.sv | 28 ++
 rtl/shift_xfer_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/shift_xfer_ctrl_pkg.sv
// Shared types for the serial shift-transfer controller: FSM state encoding
// and a counter-width helper that stays legal for a divide-by-one setting.
package shift_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // $clog2(1) is 0, which cannot size a vector; clamp to one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_pload.sv
// Right-shifting register with parallel load; serial data enters at the MSB
// and leaves from bit 0. Load has priority over shift.
module shift_reg_pload #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             so
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

  assign so = q[0];

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Sequencer for one parallel-in / serial-shift / parallel-out transfer through
// shift_reg_pload, with a held rx buffer and a sticky overrun flag.
//
//   state   | meaning
//   S_IDLE  | ready for a new word; accept loads the shift register
//   S_SHIFT | one shift every DIV cycles until WIDTH shifts are done
//   S_DONE  | one cycle: copy shift register into the rx buffer
module shift_xfer_ctrl
  import shift_xfer_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             sin,
  output logic             so,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = cnt_width(DIV);

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] divcnt;
  logic [BIT_W-1:0] bitcnt;
  logic [WIDTH-1:0] shreg_q;
  logic             load;
  logic             last_shift;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load) state_nxt = S_SHIFT;
      S_SHIFT: if (last_shift) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    busy     = 1'b0;
    shift_en = 1'b0;
    case (state)
      S_IDLE:  tx_ready = 1'b1;
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = (divcnt == DIV_W'(DIV - 1));
      end
      S_DONE:  busy = 1'b1;
      default: ;
    endcase
  end

  assign load       = tx_valid && tx_ready;
  assign last_shift = shift_en && (bitcnt == BIT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      divcnt <= '0;
      bitcnt <= '0;
    end else if (load) begin
      divcnt <= '0;
      bitcnt <= '0;
    end else if (state == S_SHIFT) begin
      if (shift_en) begin
        divcnt <= '0;
        bitcnt <= bitcnt + BIT_W'(1);
      end else begin
        divcnt <= divcnt + DIV_W'(1);
      end
    end
  end

  // A capture in S_DONE takes precedence over a same-edge consume.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (state == S_DONE) begin
      rx_data  <= shreg_q;
      rx_valid <= 1'b1;
      if (rx_valid && !rx_ready) overrun <= 1'b1;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  shift_reg_pload #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d     (tx_data),
    .shift (shift_en),
    .sin   (sin),
    .q     (shreg_q),
    .so    (so)
  );

endmodule
